key_note_scheduler: RTL



---
 rtl/key_note_scheduler_pkg.sv | 30 +++
 rtl/key_note_scheduler_note_fifo.sv | 53 +++++
 rtl/key_note_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/key_note_scheduler_pkg.sv
// Shared types and constants for the key-press note scheduler.
// State encoding, note codes and the press priority encoder live here.
package key_note_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  localparam logic [1:0] NOTE_K0 = 2'd0;
  localparam logic [1:0] NOTE_K1 = 2'd1;
  localparam logic [1:0] NOTE_K4 = 2'd2;
  localparam logic [1:0] NOTE_K7 = 2'd3;

  // Bit order of the rise vector is {key7, key4, key1, key0}; key 0 wins.
  function automatic logic [1:0] encode_rise(input logic [3:0] rise);
    logic [1:0] code;
    code = NOTE_K7;
    if (rise[2]) code = NOTE_K4;
    if (rise[1]) code = NOTE_K1;
    if (rise[0]) code = NOTE_K0;
    return code;
  endfunction

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/key_note_scheduler_note_fifo.sv
// Small synchronous FIFO of 2-bit note codes with a combinational head.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module note_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [1:0]               wr_data,
  input  logic                     rd_en,
  output logic [1:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/key_note_scheduler.sv
// Queues rising key presses from the keypad scanner and plays them one at a
// time on a shared tone generator: fixed note length, then a silent gap.
module key_note_scheduler
  import key_note_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NOTE_LEN = 5000000,
  parameter int unsigned GAP_LEN  = 500000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_0,
  input  logic                   push_1,
  input  logic                   push_4,
  input  logic                   push_7,
  input  logic                   stop,
  output logic                   tone_en,
  output logic [1:0]             tone_sel,
  output logic                   note_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   dropped
);

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);
  localparam bit               HAS_GAP   = (GAP_LEN != 0);
  localparam bit               ONE_CYCLE = (NOTE_LEN == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       keys;
  logic [3:0]       keys_q;
  logic [3:0]       rise;
  logic             armed;
  logic             any_rise;
  logic             multi_rise;
  logic [1:0]       wr_code;
  logic [1:0]       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             slot_free;
  logic             pop;

  assign keys = {push_7, push_4, push_1, push_0};

  // armed stays low for the first edge after reset so a key held through
  // reset is absorbed into the history instead of counting as a new press.
  assign rise       = armed ? (keys & ~keys_q) : '0;
  assign any_rise   = |rise;
  assign multi_rise = multi_hot(rise);
  assign wr_code    = encode_rise(rise);

  assign slot_free = (state == S_IDLE) ||
                     ((cnt == '0) && ((state == S_GAP) || ((state == S_PLAY) && !HAS_GAP)));
  assign pop  = ~stop & ~fifo_empty & slot_free;
  assign busy = (state != S_IDLE) | ~fifo_empty;

  note_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (stop),
    .wr_en   (any_rise & ~stop),
    .wr_data (wr_code),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keys_q  <= '0;
      armed   <= 1'b0;
      dropped <= 1'b0;
    end else begin
      keys_q  <= keys;
      armed   <= 1'b1;
      dropped <= ~stop & (multi_rise | (any_rise & fifo_full & ~pop));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tone_en   <= 1'b0;
      tone_sel  <= '0;
      note_done <= 1'b0;
    end else begin
      note_done <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        cnt     <= '0;
        tone_en <= 1'b0;
      end else if (pop) begin
        // Covers IDLE start, end of gap and back-to-back notes without a gap.
        state     <= S_PLAY;
        tone_sel  <= head;
        cnt       <= NOTE_LOAD;
        tone_en   <= 1'b1;
        note_done <= ONE_CYCLE;
      end else begin
        case (state)
          S_PLAY: begin
            if (cnt == '0) begin
              tone_en <= 1'b0;
              if (HAS_GAP) begin
                state <= S_GAP;
                cnt   <= GAP_LOAD;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt       <= cnt - 1'b1;
              note_done <= (cnt == CNT_W'(1));
            end
          end
          S_GAP: begin
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
